// File: rtl/fence_ctrl.sv
// fence_ctrl: sequences LSU drain, D$ writeback, I$ invalidate and TLB flush after a fence, then redirects fetch.
// Build option FENCE_TLB_EN adds the TLB flush step for SFENCE.VMA; without it SFENCE.VMA acts as FENCE.
module fence_ctrl #(
  parameter int unsigned WAIT_MAX = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fence_req_i,
  input  logic [1:0]  fence_type_i,
  input  logic [31:0] fence_pc_i,
  output logic        fence_busy_o,
  input  logic        lsu_idle_i,
  output logic        dcache_flush_o,
  input  logic        dcache_flush_done_i,
  output logic        icache_inv_o,
  input  logic        icache_inv_done_i,
  output logic        tlb_flush_o,
  output logic        branch_request_o,
  output logic [31:0] branch_pc_o,
  output logic        fence_timeout_o
);

  localparam int unsigned CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WAIT_MAX);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_DFLUSH = 3'd2,
    ST_IFLUSH = 3'd3,
`ifdef FENCE_TLB_EN
    ST_TLB    = 3'd4,
`endif
    ST_RESUME = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  type_q, type_d;
  logic [31:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
  logic        wait_s;
  logic        expire_s;

  logic        busy_q;
  logic        dflush_q;
  logic        icinv_q;
  logic        branch_q;

  // Successor of DRAIN for each latched fence type.
  function automatic state_e drain_exit_f(input logic [1:0] ftype);
    state_e nxt;
    case (ftype)
      2'd1:    nxt = ST_DFLUSH;
`ifdef FENCE_TLB_EN
      2'd2:    nxt = ST_TLB;
`endif
      default: nxt = ST_RESUME;
    endcase
    return nxt;
  endfunction

  // Next-state, latch and wait-counter logic.
  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    pc_d     = pc_q;
    tmo_d    = tmo_q;
    wait_s   = 1'b0;
    expire_s = (cnt_q == CNT_LAST);
    case (state_q)
      ST_IDLE: begin
        if (fence_req_i) begin
          state_d = ST_DRAIN;
          type_d  = (fence_type_i == 2'd3) ? 2'd0 : fence_type_i;
          pc_d    = fence_pc_i;
          tmo_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        wait_s = 1'b1;
        if (lsu_idle_i || expire_s) begin
          state_d = drain_exit_f(type_q);
          tmo_d   = tmo_q | ~lsu_idle_i;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DFLUSH: begin
        wait_s = 1'b1;
        if (dcache_flush_done_i || expire_s) begin
          state_d = ST_IFLUSH;
          tmo_d   = tmo_q | ~dcache_flush_done_i;
        end else begin
          state_d = ST_DFLUSH;
        end
      end
      ST_IFLUSH: begin
        wait_s = 1'b1;
        if (icache_inv_done_i || expire_s) begin
          state_d = ST_RESUME;
          tmo_d   = tmo_q | ~icache_inv_done_i;
        end else begin
          state_d = ST_IFLUSH;
        end
      end
`ifdef FENCE_TLB_EN
      ST_TLB: begin
        state_d = ST_RESUME;
      end
`endif
      ST_RESUME: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Counter restarts on every transition so each wait state gets its own budget.
    if (state_d != state_q) begin
      cnt_d = CNT_ZERO;
    end else if (wait_s && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Sequencer state, latched request and sticky timeout.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      type_q  <= 2'd0;
      pc_q    <= 32'h0;
      cnt_q   <= CNT_ZERO;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Output flops track the state being entered, so they change with state_q and never see inputs directly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      dflush_q <= 1'b0;
      icinv_q  <= 1'b0;
      branch_q <= 1'b0;
    end else begin
      busy_q   <= (state_d != ST_IDLE);
      dflush_q <= (state_d == ST_DFLUSH);
      icinv_q  <= (state_d == ST_IFLUSH);
      branch_q <= (state_d == ST_RESUME);
    end
  end

`ifdef FENCE_TLB_EN
  logic tlb_q;

  // Single-cycle TLB flush pulse for SFENCE.VMA.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tlb_q <= 1'b0;
    end else begin
      tlb_q <= (state_d == ST_TLB);
    end
  end

  assign tlb_flush_o = tlb_q;
`else
  assign tlb_flush_o = 1'b0;
`endif

  assign fence_busy_o     = busy_q;
  assign dcache_flush_o   = dflush_q;
  assign icache_inv_o     = icinv_q;
  assign branch_request_o = branch_q;
  assign branch_pc_o      = pc_q;
  assign fence_timeout_o  = tmo_q;

endmodule

// File: tb/tb_fence_ctrl.sv
// Self-checking bench for fence_ctrl: per-cycle comparison against a segment-length model of each fence.
// Honours FENCE_TLB_EN the same way as the design.
module tb_fence_ctrl;
  localparam int WM = 8;

  localparam int L_IDLE = 0;
  localparam int L_DRAIN = 1;
  localparam int L_DF = 2;
  localparam int L_IF = 3;
  localparam int L_TLB = 4;
  localparam int L_RES = 5;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fence_req_i;
  logic [1:0]  fence_type_i;
  logic [31:0] fence_pc_i;
  logic        fence_busy_o;
  logic        lsu_idle_i;
  logic        dcache_flush_o;
  logic        dcache_flush_done_i;
  logic        icache_inv_o;
  logic        icache_inv_done_i;
  logic        tlb_flush_o;
  logic        branch_request_o;
  logic [31:0] branch_pc_o;
  logic        fence_timeout_o;

  int checks = 0;
  int errors = 0;

  int exp_st[$];
  int exp_t[$];
  bit exp_tmo[$];
  bit model_tmo;
  bit cur_tmo;
  logic [31:0] exp_pc;

  fence_ctrl #(.WAIT_MAX(WM)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .fence_req_i(fence_req_i), .fence_type_i(fence_type_i), .fence_pc_i(fence_pc_i),
    .fence_busy_o(fence_busy_o), .lsu_idle_i(lsu_idle_i),
    .dcache_flush_o(dcache_flush_o), .dcache_flush_done_i(dcache_flush_done_i),
    .icache_inv_o(icache_inv_o), .icache_inv_done_i(icache_inv_done_i),
    .tlb_flush_o(tlb_flush_o), .branch_request_o(branch_request_o),
    .branch_pc_o(branch_pc_o), .fence_timeout_o(fence_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_flags();
    return {26'd0, fence_busy_o, dcache_flush_o, icache_inv_o, tlb_flush_o, branch_request_o, fence_timeout_o};
  endfunction

  function automatic logic [31:0] flags_of(input int st, input bit tmo);
    return {26'd0, (st != L_IDLE), (st == L_DF), (st == L_IF), (st == L_TLB), (st == L_RES), tmo};
  endfunction

  task automatic push(input int st, input int n, input bit tmo);
    for (int i = 0; i < n; i++) begin
      exp_st.push_back(st);
      exp_t.push_back(i);
      exp_tmo.push_back(tmo);
    end
  endtask

  // Model: each wait lasts until its input is seen, capped at WM cycles (cap without input = timeout).
  task automatic build(input int ty, input int dl, input int dd, input int di);
    int eff;
    bit tmo;
    exp_st.delete();
    exp_t.delete();
    exp_tmo.delete();
    eff = (ty == 3) ? 0 : ty;
`ifndef FENCE_TLB_EN
    if (eff == 2) eff = 0;
`endif
    tmo = 1'b0;
    push(L_DRAIN, (dl < WM) ? dl + 1 : WM, tmo);
    if (dl >= WM) tmo = 1'b1;
    if (eff == 1) begin
      push(L_DF, (dd <= WM) ? dd : WM, tmo);
      if (dd > WM) tmo = 1'b1;
      push(L_IF, (di <= WM) ? di : WM, tmo);
      if (di > WM) tmo = 1'b1;
    end else if (eff == 2) begin
      push(L_TLB, 1, tmo);
    end
    push(L_RES, 1, tmo);
    model_tmo = tmo;
  endtask

  // dl: cycles lsu_idle_i stays low in DRAIN; dd/di: cycle (1-based) of the done pulse; abort_k: reset at that step.
  task automatic run_fence(input int ty, input logic [31:0] pc, input int dl, input int dd, input int di,
                           input bit noisy, input int abort_k);
    build(ty, dl, dd, di);
    @(negedge clk_i);
    check("idle_flags", obs_flags(), flags_of(L_IDLE, cur_tmo));
    check("idle_pc", branch_pc_o, exp_pc);
    fence_req_i = 1'b1;
    fence_type_i = 2'(ty);
    fence_pc_i = pc;
    lsu_idle_i = 1'($urandom_range(0, 1));
    dcache_flush_done_i = noisy && ($urandom_range(0, 1) == 0);
    icache_inv_done_i = noisy && ($urandom_range(0, 1) == 0);
    for (int k = 0; k < exp_st.size(); k++) begin
      @(negedge clk_i);
      check($sformatf("seq_flags ty=%0d k=%0d", ty, k), obs_flags(), flags_of(exp_st[k], exp_tmo[k]));
      check($sformatf("seq_pc ty=%0d k=%0d", ty, k), branch_pc_o, pc);
      if (k == abort_k) begin
        #1 rst_i = 1'b1;
        #1;
        check("rst_flags", obs_flags(), 32'd0);
        check("rst_pc", branch_pc_o, 32'd0);
        fence_req_i = 1'b0;
        lsu_idle_i = 1'b0;
        dcache_flush_done_i = 1'b0;
        icache_inv_done_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_pc = 32'd0;
        cur_tmo = 1'b0;
        return;
      end
      fence_req_i = noisy && (exp_st[k] == L_DF || $urandom_range(0, 2) == 0);
      fence_type_i = 2'($urandom_range(0, 3));
      fence_pc_i = $urandom;
      lsu_idle_i = (exp_st[k] == L_DRAIN) ? (exp_t[k] >= dl) : 1'($urandom_range(0, 1));
      dcache_flush_done_i = (exp_st[k] == L_DF) ? (exp_t[k] == dd - 1)
                                                : (noisy && $urandom_range(0, 3) == 0);
      icache_inv_done_i = (exp_st[k] == L_IF) ? (exp_t[k] == di - 1)
                                              : (noisy && $urandom_range(0, 3) == 0);
    end
    exp_pc = pc;
    cur_tmo = model_tmo;
  endtask

  initial begin
    rst_i = 1'b1;
    fence_req_i = 1'b0;
    fence_type_i = 2'd0;
    fence_pc_i = 32'd0;
    lsu_idle_i = 1'b0;
    dcache_flush_done_i = 1'b0;
    icache_inv_done_i = 1'b0;
    cur_tmo = 1'b0;
    exp_pc = 32'd0;
    @(negedge clk_i);
    check("reset_flags", obs_flags(), 32'd0);
    check("reset_pc", branch_pc_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    run_fence(0, 32'h8000_0104, 0, 1, 1, 1'b0, -1);
    run_fence(1, 32'h8000_0200, 5, 3, 2, 1'b0, -1);
    run_fence(1, 32'h8000_0220, 0, 1, 1, 1'b0, -1);
    run_fence(2, 32'h8000_0300, 0, 1, 1, 1'b0, -1);
    run_fence(3, 32'h8000_0400, 2, 1, 1, 1'b0, -1);
    run_fence(0, 32'h8000_0500, 20, 1, 1, 1'b0, -1);
    run_fence(1, 32'h8000_0600, WM - 1, WM, WM + 1, 1'b0, -1);
    run_fence(1, 32'h8000_0700, 1, 4, 2, 1'b1, -1);
    run_fence(1, 32'h8000_0800, 1, 2, 5, 1'b1, 4);
    run_fence(0, 32'h8000_0900, 0, 1, 1, 1'b0, -1);
    run_fence(1, 32'h8000_0a00, 1, WM + 3, 1, 1'b1, -1);

    for (int n = 0; n < 40; n++) begin
      run_fence(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 10)),
                int'($urandom_range(1, 10)), int'($urandom_range(1, 10)), 1'b1, -1);
    end

    @(negedge clk_i);
    check("final_flags", obs_flags(), flags_of(L_IDLE, cur_tmo));
    check("final_pc", branch_pc_o, exp_pc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
